char_buffer_engine: RTL

Parametrised single-clock character buffer that holds one ASCII/colour/highlight cell per text position. It serves a display read port with fixed latency and accepts random-access cell writes from the active mode. It also runs two self-timed bulk operations, CLEAR (fill every cell) and SCROLL_UP (shift all rows up one and blank the bottom row). It sits between the mode logic and the VGA character renderer, and supports any text grid size through parameters.

---
 rtl/char_buffer_pkg.sv | 29 ++
 rtl/char_buffer_engine_coords_to_addr.sv | 22 ++
 rtl/char_buffer_engine.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/char_buffer_pkg.sv
// Shared definitions for the character buffer: command codes, engine states,
// fill-cell constants and the default-width cell layout.
package char_buffer_pkg;

  localparam logic [1:0] CMD_CLEAR     = 2'd0;
  localparam logic [1:0] CMD_SCROLL_UP = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_SCROLL  = 2'd2,
    ST_CLR_ROW = 2'd3
  } state_e;

  // Wide fill constants; users truncate to their own field widths.
  localparam logic [31:0] NIL  = 32'h0000_0000;
  localparam logic [31:0] NCLR = 32'hFFFF_FFFF;
  localparam logic        NHL  = 1'b1;

  localparam int DEF_ASCII_W  = 7;
  localparam int DEF_COLOUR_W = 6;

  typedef struct packed {
    logic [DEF_ASCII_W-1:0]  ascii;
    logic [DEF_COLOUR_W-1:0] colour;
    logic                    hl;
  } cell_t;

endpackage

// File: rtl/char_buffer_engine_coords_to_addr.sv
// Linear cell address y*COLS + x with an out-of-bounds flag.
module coords_to_addr
  import char_buffer_pkg::*;
#(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int X_W    = 7,
  parameter int Y_W    = 6,
  parameter int ADDR_W = 13
) (
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              oob
);

  always_comb begin
    oob  = (int'(x) >= COLS) || (int'(y) >= ROWS);
    addr = ADDR_W'(int'(y) * COLS + int'(x));
  end

endmodule

// File: rtl/char_buffer_engine.sv
// Character cell buffer: 2-cycle display read port, random-access writes and a
// self-timed CLEAR / SCROLL_UP engine that owns the memory while busy.
module char_buffer_engine
  import char_buffer_pkg::*;
#(
  parameter int COLS           = 80,
  parameter int ROWS           = 60,
  parameter int ASCII_W        = 7,
  parameter int COLOUR_W       = 6,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int X_W    = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int Y_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int N      = COLS * ROWS,
  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [X_W-1:0]      wrx,
  input  logic [Y_W-1:0]      wry,
  input  logic                wren,
  input  logic                hien,
  input  logic [ASCII_W-1:0]  wascii,
  input  logic [COLOUR_W-1:0] wcolour,
  input  logic                highlight,
  input  logic [X_W-1:0]      rex,
  input  logic [Y_W-1:0]      rey,
  output logic [ASCII_W-1:0]  rascii,
  output logic [COLOUR_W-1:0] rcolour,
  output logic                rhighlight,
  output logic                rvalid,
  input  logic                cmd_valid,
  input  logic [1:0]          cmd_op,
  output logic                cmd_ready,
  output logic                busy
);

  typedef struct packed {
    logic [ASCII_W-1:0]  ascii;
    logic [COLOUR_W-1:0] colour;
    logic                hl;
  } pcell_t;

  localparam pcell_t FILL = '{ascii: ASCII_W'(NIL), colour: COLOUR_W'(NCLR), hl: NHL};
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ROW_BASE = ADDR_W'(N - COLS);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  logic [ADDR_W-1:0] waddr_usr, raddr_usr;
  logic              woob, roob;

  coords_to_addr #(.COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) u_wr_addr (
    .x(wrx), .y(wry), .addr(waddr_usr), .oob(woob)
  );

  coords_to_addr #(.COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) u_rd_addr (
    .x(rex), .y(rey), .addr(raddr_usr), .oob(roob)
  );

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              mem_we_ac, mem_we_hl;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  pcell_t            mem_wdata, mem_rd_q;
  pcell_t            mem [N];

  assign busy      = (state_q != ST_IDLE);
  assign cmd_ready = !busy;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we_ac = 1'b0;
    mem_we_hl = 1'b0;
    mem_waddr = waddr_usr;
    mem_wdata = '{ascii: wascii, colour: wcolour, hl: highlight};
    mem_raddr = roob ? '0 : raddr_usr;
    case (state_q)
      ST_IDLE: begin
        mem_we_ac = wren & ~woob;
        mem_we_hl = hien & ~woob;
        if (cmd_valid) begin
          ptr_d = '0;
          if (cmd_op == CMD_CLEAR) begin
            state_d = ST_CLEAR;
          end else if (cmd_op == CMD_SCROLL_UP) begin
            // A single-row grid has nothing to shift; ptr 0 is already the bottom row.
            state_d = (ROWS > 1) ? ST_SCROLL : ST_CLR_ROW;
          end
        end
      end
      ST_CLEAR, ST_CLR_ROW: begin
        mem_we_ac = 1'b1;
        mem_we_hl = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = FILL;
        ptr_d     = ptr_q + ONE_A;
        if (ptr_q == LAST) state_d = ST_IDLE;
      end
      ST_SCROLL: begin
        // Read one row below now, write it one row up next cycle.
        if (ptr_q != ROW_BASE) mem_raddr = ptr_q + COLS_A;
        if (ptr_q != '0) begin
          mem_we_ac = 1'b1;
          mem_we_hl = 1'b1;
          mem_waddr = ptr_q - ONE_A;
          mem_wdata = mem_rd_q;
        end
        if (ptr_q == ROW_BASE) state_d = ST_CLR_ROW;
        else                   ptr_d   = ptr_q + ONE_A;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we_ac) begin
      mem[mem_waddr].ascii  <= mem_wdata.ascii;
      mem[mem_waddr].colour <= mem_wdata.colour;
    end
    if (mem_we_hl) mem[mem_waddr].hl <= mem_wdata.hl;
    mem_rd_q <= mem[mem_raddr];
  end

  // Display pipeline: validity and OOB travel with the data.
  logic   rv1_q, rv1_d, roob1_q, roob1_d;
  logic   rv2_q, rv2_d, roob2_q, roob2_d;
  pcell_t rdata2_q, rdata2_d, out_cell;

  always_comb begin
    rv1_d    = !busy;
    roob1_d  = roob;
    rv2_d    = rv1_q;
    roob2_d  = roob1_q;
    rdata2_d = mem_rd_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rv1_q    <= 1'b0;
      roob1_q  <= 1'b0;
      rv2_q    <= 1'b0;
      roob2_q  <= 1'b0;
      rdata2_q <= FILL;
    end else begin
      rv1_q    <= rv1_d;
      roob1_q  <= roob1_d;
      rv2_q    <= rv2_d;
      roob2_q  <= roob2_d;
      rdata2_q <= rdata2_d;
    end
  end

  assign out_cell   = (rv2_q && !roob2_q) ? rdata2_q : FILL;
  assign rascii     = out_cell.ascii;
  assign rcolour    = out_cell.colour;
  assign rhighlight = out_cell.hl;
  assign rvalid     = rv2_q;

endmodule
